// File: rtl/abd2pcim_wr_master_if.sv
// PCIM AXI4 write-channel bundle between the CL write master and the shell.
// Ports (modports):
//   master : drives AW/W/bready, samples awready/wready/B channel
//   slave  : mirror image, used by the shell side or a bench model
interface abd2pcim_wr_master_if #(
  parameter int unsigned AXI_ID_W = 16
);
  logic [AXI_ID_W-1:0] cl_sh_pcim_awid;
  logic [63:0]         cl_sh_pcim_awaddr;
  logic [7:0]          cl_sh_pcim_awlen;
  logic [2:0]          cl_sh_pcim_awsize;
  logic                cl_sh_pcim_awvalid;
  logic                sh_cl_pcim_awready;
  logic [511:0]        cl_sh_pcim_wdata;
  logic [63:0]         cl_sh_pcim_wstrb;
  logic                cl_sh_pcim_wlast;
  logic                cl_sh_pcim_wvalid;
  logic                sh_cl_pcim_wready;
  logic [AXI_ID_W-1:0] sh_cl_pcim_bid;
  logic [1:0]          sh_cl_pcim_bresp;
  logic                sh_cl_pcim_bvalid;
  logic                cl_sh_pcim_bready;

  modport master (
    output cl_sh_pcim_awid, cl_sh_pcim_awaddr, cl_sh_pcim_awlen, cl_sh_pcim_awsize,
           cl_sh_pcim_awvalid, cl_sh_pcim_wdata, cl_sh_pcim_wstrb, cl_sh_pcim_wlast,
           cl_sh_pcim_wvalid, cl_sh_pcim_bready,
    input  sh_cl_pcim_awready, sh_cl_pcim_wready, sh_cl_pcim_bid, sh_cl_pcim_bresp,
           sh_cl_pcim_bvalid
  );

  modport slave (
    input  cl_sh_pcim_awid, cl_sh_pcim_awaddr, cl_sh_pcim_awlen, cl_sh_pcim_awsize,
           cl_sh_pcim_awvalid, cl_sh_pcim_wdata, cl_sh_pcim_wstrb, cl_sh_pcim_wlast,
           cl_sh_pcim_wvalid, cl_sh_pcim_bready,
    output sh_cl_pcim_awready, sh_cl_pcim_wready, sh_cl_pcim_bid, sh_cl_pcim_bresp,
           sh_cl_pcim_bvalid
  );
endinterface

// File: rtl/abd2pcim_wr_master.sv
// ABD -> PCIM write master: takes one write request (64-bit byte address,
// AXI burst length) plus a 512-bit beat stream and issues a single AW/W burst
// to host memory, then reports the B response on the done port.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/addr/len     request handshake
//   data_valid/data_ready/data       beat stream, passed straight to W
//   done_valid/done_resp             one-cycle completion with AXI resp
//   pcim                             PCIM AXI write channels (master modport)
// Optional: define PCIM_WR_TIMEOUT_EN to add a B-response watchdog of
// TIMEOUT_CYCLES cycles (resp 2'b11 on expiry, late B silently absorbed).
module abd2pcim_wr_master #(
  parameter int unsigned AXI_ID_W       = 16,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  input  logic [7:0]    req_len,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic [511:0]  data,
  output logic          done_valid,
  output logic [1:0]    done_resp,
  abd2pcim_wr_master_if.master pcim
);

  typedef enum logic [1:0] {IDLE, CHECK, BURST, RESP} state_t;

  state_t      state, state_nxt;
  logic [63:0] addr_q, addr_nxt;
  logic [7:0]  len_q, len_nxt;
  logic [7:0]  beat_q, beat_nxt;
  logic        awvalid_q, awvalid_nxt;
  logic        aw_done_q, aw_done_nxt;
  logic        w_done_q, w_done_nxt;
  logic        done_valid_q, done_valid_nxt;
  logic [1:0]  done_resp_q, done_resp_nxt;
  logic        req_ready_q, req_ready_nxt;
  logic        bready_q, bready_nxt;

  logic        aw_hs_c, w_open_c, w_hs_c, wlast_c, b_hs_c, reject_c;
  logic [8:0]  span_c;

`ifdef PCIM_WR_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic             late_q, late_nxt;
`endif

  // W is open only in BURST until the last beat has gone, so a stalled AW
  // never lets extra beats through.
  assign aw_hs_c  = awvalid_q & pcim.sh_cl_pcim_awready;
  assign w_open_c = (state == BURST) & ~w_done_q;
  assign w_hs_c   = w_open_c & data_valid & pcim.sh_cl_pcim_wready;
  assign wlast_c  = w_open_c & (beat_q == len_q);
  assign b_hs_c   = bready_q & pcim.sh_cl_pcim_bvalid;

  // Reject misaligned bursts and bursts crossing a 4 KiB page.
  assign span_c   = 9'(addr_q[11:6]) + 9'(len_q);
  assign reject_c = (addr_q[5:0] != 6'd0) | (span_c > 9'd63);

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_q;
    len_nxt        = len_q;
    beat_nxt       = beat_q;
    awvalid_nxt    = awvalid_q;
    aw_done_nxt    = aw_done_q;
    w_done_nxt     = w_done_q;
    done_valid_nxt = 1'b0;
    done_resp_nxt  = done_resp_q;
`ifdef PCIM_WR_TIMEOUT_EN
    tmo_nxt        = tmo_q;
    late_nxt       = late_q;
    // A late B after a timeout is accepted and dropped outside RESP.
    if (late_q && pcim.sh_cl_pcim_bvalid && (state != RESP)) late_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_nxt  = req_addr;
          len_nxt   = req_len;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (reject_c) begin
          done_valid_nxt = 1'b1;
          done_resp_nxt  = 2'b10;
          state_nxt      = IDLE;
        end else begin
          awvalid_nxt = 1'b1;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          beat_nxt    = 8'd0;
          state_nxt   = BURST;
        end
      end
      BURST: begin
        if (aw_hs_c) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_hs_c) begin
          beat_nxt = beat_q + 8'd1;
          if (wlast_c) w_done_nxt = 1'b1;
        end
        // AW and the last W beat may complete in either order.
        if ((w_done_q || (w_hs_c && wlast_c)) && (aw_done_q || aw_hs_c)) begin
          state_nxt = RESP;
`ifdef PCIM_WR_TIMEOUT_EN
          tmo_nxt   = '0;
`endif
        end
      end
      RESP: begin
        if (b_hs_c) begin
          done_valid_nxt = 1'b1;
          done_resp_nxt  = pcim.sh_cl_pcim_bresp;
          state_nxt      = IDLE;
`ifdef PCIM_WR_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          done_valid_nxt = 1'b1;
          done_resp_nxt  = 2'b11;
          late_nxt       = 1'b1;
          state_nxt      = IDLE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Ready only after a full IDLE cycle, i.e. never in the done cycle.
    req_ready_nxt = (state == IDLE) && (state_nxt == IDLE);
`ifdef PCIM_WR_TIMEOUT_EN
    bready_nxt    = (state_nxt == RESP) || late_nxt;
`else
    bready_nxt    = (state_nxt == RESP);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      awvalid_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_resp_q  <= 2'b00;
      req_ready_q  <= 1'b0;
      bready_q     <= 1'b0;
`ifdef PCIM_WR_TIMEOUT_EN
      tmo_q        <= '0;
      late_q       <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      addr_q       <= addr_nxt;
      len_q        <= len_nxt;
      beat_q       <= beat_nxt;
      awvalid_q    <= awvalid_nxt;
      aw_done_q    <= aw_done_nxt;
      w_done_q     <= w_done_nxt;
      done_valid_q <= done_valid_nxt;
      done_resp_q  <= done_resp_nxt;
      req_ready_q  <= req_ready_nxt;
      bready_q     <= bready_nxt;
`ifdef PCIM_WR_TIMEOUT_EN
      tmo_q        <= tmo_nxt;
      late_q       <= late_nxt;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign data_ready = w_open_c & pcim.sh_cl_pcim_wready;
  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;

  assign pcim.cl_sh_pcim_awid    = AXI_ID_W'(AXI_ID);
  assign pcim.cl_sh_pcim_awaddr  = addr_q;
  assign pcim.cl_sh_pcim_awlen   = len_q;
  assign pcim.cl_sh_pcim_awsize  = 3'b110;
  assign pcim.cl_sh_pcim_awvalid = awvalid_q;
  assign pcim.cl_sh_pcim_wdata   = data;
  assign pcim.cl_sh_pcim_wstrb   = {64{1'b1}};
  assign pcim.cl_sh_pcim_wlast   = wlast_c;
  assign pcim.cl_sh_pcim_wvalid  = w_open_c & data_valid;
  assign pcim.cl_sh_pcim_bready  = bready_q;

  // B id is not checked; the watchdog limit is unused in the default build.
  logic unused_ok;
  assign unused_ok = &{1'b0, pcim.sh_cl_pcim_bid, 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_abd2pcim_wr_master.sv
module tb_abd2pcim_wr_master;
  localparam int unsigned AXI_ID_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready;
  logic [63:0]   req_addr;
  logic [7:0]    req_len;
  logic          data_valid, data_ready;
  logic [511:0]  data;
  logic          done_valid;
  logic [1:0]    done_resp;

  abd2pcim_wr_master_if #(.AXI_ID_W(AXI_ID_W)) pcim_if ();

  abd2pcim_wr_master #(.AXI_ID_W(AXI_ID_W), .AXI_ID(0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .done_valid(done_valid), .done_resp(done_resp),
    .pcim(pcim_if.master)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [511:0] d; logic last; } w_t;

  aw_t          aw_q[$];
  w_t           w_q[$];
  logic [1:0]   done_q[$];
  logic [1:0]   bq[$];
  logic [511:0] src_q[$];

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 awready held until 5 cycles after wlast
  int dv_mode  = 0;   // 0 data always valid when available, 1 random gaps
  bit b_en     = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference rule: aligned to 64 B and staying within one 4 KiB page.
  function automatic bit ref_reject(input logic [63:0] addr, input logic [7:0] len);
    longint unsigned a, first_beat;
    a = addr;
    first_beat = (a % 4096) / 64;
    return ((a % 64) != 0) || ((first_beat + longint'(len)) > 63);
  endfunction

  // AW/W ready generator.
  initial begin
    bit wl, awhs, seen;
    int cnt;
    seen = 0; cnt = 0;
    pcim_if.sh_cl_pcim_awready = 1'b0;
    pcim_if.sh_cl_pcim_wready  = 1'b0;
    forever begin
      @(negedge clk);
      wl   = pcim_if.cl_sh_pcim_wvalid && pcim_if.sh_cl_pcim_wready && pcim_if.cl_sh_pcim_wlast;
      awhs = pcim_if.cl_sh_pcim_awvalid && pcim_if.sh_cl_pcim_awready;
      @(posedge clk); #1;
      if (awhs) begin seen = 0; cnt = 0; end
      if (wl) begin seen = 1; cnt = 0; end
      else if (seen) cnt++;
      case (rdy_mode)
        0: begin pcim_if.sh_cl_pcim_awready = 1'b1; pcim_if.sh_cl_pcim_wready = 1'b1; end
        1: begin
          pcim_if.sh_cl_pcim_awready = ($urandom_range(0, 3) == 0);
          pcim_if.sh_cl_pcim_wready  = ($urandom_range(0, 1) == 1);
        end
        default: begin
          pcim_if.sh_cl_pcim_wready  = 1'b1;
          pcim_if.sh_cl_pcim_awready = seen && (cnt >= 5);
        end
      endcase
    end
  end

  // Beat source: holds valid until consumed.
  initial begin
    bit hs;
    data_valid = 1'b0;
    data = '0;
    forever begin
      @(negedge clk);
      hs = data_valid && data_ready;
      @(posedge clk); #1;
      if (hs) void'(src_q.pop_front());
      if (data_valid && !hs) begin
      end else if (src_q.size() > 0 && (dv_mode == 0 || $urandom_range(0, 2) != 0)) begin
        data_valid = 1'b1;
        data = src_q[0];
      end else begin
        data_valid = 1'b0;
      end
    end
  end

  // B responder.
  initial begin
    bit hs;
    pcim_if.sh_cl_pcim_bvalid = 1'b0;
    pcim_if.sh_cl_pcim_bresp  = 2'b00;
    pcim_if.sh_cl_pcim_bid    = '0;
    forever begin
      @(negedge clk);
      hs = pcim_if.sh_cl_pcim_bvalid && pcim_if.cl_sh_pcim_bready;
      @(posedge clk); #1;
      if (hs) begin
        pcim_if.sh_cl_pcim_bvalid = 1'b0;
        if (bq.size() > 0) void'(bq.pop_front());
      end else if (!pcim_if.sh_cl_pcim_bvalid && b_en && pcim_if.cl_sh_pcim_bready &&
                   bq.size() > 0 && $urandom_range(0, 3) != 0) begin
        pcim_if.sh_cl_pcim_bvalid = 1'b1;
        pcim_if.sh_cl_pcim_bresp  = bq[0];
        pcim_if.sh_cl_pcim_bid    = AXI_ID_W'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit done_pending, bready_prev;
    aw_t ea;
    w_t  ew;
    logic [1:0] er;
    done_pending = 0;
    bready_prev  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done_pending) begin
          check("req_ready_after_done", 64'(req_ready), 64'd1);
          done_pending = 0;
        end
        if (pcim_if.cl_sh_pcim_awvalid) begin
          if (aw_q.size() == 0) fail_event("aw_unexpected");
          else if (pcim_if.sh_cl_pcim_awready) begin
            ea = aw_q.pop_front();
            check("awaddr", pcim_if.cl_sh_pcim_awaddr, ea.addr);
            check("awlen", 64'(pcim_if.cl_sh_pcim_awlen), 64'(ea.len));
            check("awid", 64'(pcim_if.cl_sh_pcim_awid), 64'd0);
            check("awsize", 64'(pcim_if.cl_sh_pcim_awsize), 64'd6);
          end
        end
        if (pcim_if.cl_sh_pcim_wvalid) begin
          if (w_q.size() == 0) fail_event("w_unexpected");
          else if (pcim_if.sh_cl_pcim_wready) begin
            ew = w_q.pop_front();
            check_wide("wdata", pcim_if.cl_sh_pcim_wdata, ew.d);
            check("wlast", 64'(pcim_if.cl_sh_pcim_wlast), 64'(ew.last));
            check("wstrb", pcim_if.cl_sh_pcim_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
          end
        end
        if (pcim_if.cl_sh_pcim_bready && !bready_prev) begin
          check("resp_entry_aw_pending", 64'(aw_q.size()), 64'd0);
          check("resp_entry_w_pending", 64'(w_q.size()), 64'd0);
        end
        bready_prev = pcim_if.cl_sh_pcim_bready;
        if (done_valid) begin
          if (done_q.size() == 0) fail_event("done_unexpected");
          else begin
            er = done_q.pop_front();
            check("done_resp", 64'(done_resp), 64'(er));
            check("req_ready_in_done_cycle", 64'(req_ready), 64'd0);
            done_pending = 1;
          end
        end
      end else bready_prev = 0;
    end
  end

  task automatic flush();
    aw_q.delete(); w_q.delete(); done_q.delete(); bq.delete(); src_q.delete();
  endtask

  task automatic issue(input logic [63:0] addr, input logic [7:0] len, output bit ok);
    int n;
    ok = 1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_len = len;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 500) begin
        check("req_accept_timeout", 64'd0, 64'd1);
        ok = 0;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = {$urandom, $urandom};
    req_len = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    if (done_q.size() > 0) begin
      check("done_wait_timeout", 64'(done_q.size()), 64'd0);
      flush();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_req(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] resp);
    bit rej, ok;
    logic [511:0] d;
    aw_t a;
    w_t  w;
    rej = ref_reject(addr, len);
    if (!rej) begin
      a.addr = addr; a.len = len;
      aw_q.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
        d = rand512();
        src_q.push_back(d);
        w.d = d; w.last = (i == int'(len));
        w_q.push_back(w);
      end
      bq.push_back(resp);
      done_q.push_back(resp);
    end else begin
      done_q.push_back(2'b10);
    end
    issue(addr, len, ok);
    if (!ok) begin flush(); return; end
    if (rej) begin
      @(negedge clk);
      check("reject_lat_cycle1", 64'(done_valid), 64'd0);
      @(negedge clk);
      check("reject_lat_cycle2", 64'(done_valid), 64'd1);
    end
    wait_done();
  endtask

  initial begin
    logic [63:0] addr;
    logic [7:0]  len;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_awvalid", 64'(pcim_if.cl_sh_pcim_awvalid), 64'd0);
    check("rst_wvalid", 64'(pcim_if.cl_sh_pcim_wvalid), 64'd0);
    check("rst_bready", 64'(pcim_if.cl_sh_pcim_bready), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("req_ready_after_reset", 64'(req_ready), 64'd1);

    rdy_mode = 0; dv_mode = 0;
    do_req(64'h1000, 8'd3, 2'b00);
    rdy_mode = 2;
    do_req(64'h2000, 8'd0, 2'b00);
    rdy_mode = 2;
    do_req(64'h5040, 8'd2, 2'b01);
    rdy_mode = 0;
    do_req(64'h1FC0, 8'd1, 2'b00);
    do_req(64'h1004, 8'd3, 2'b00);
    do_req(64'h4F00, 8'd3, 2'b01);
    do_req(64'h4F00, 8'd4, 2'b00);
    do_req(64'h0, 8'd255, 2'b00);
    do_req(64'h7000, 8'd63, 2'b00);
    rdy_mode = 1; dv_mode = 1;
    do_req(64'h3000, 8'd7, 2'($urandom));

    for (int i = 0; i < 25; i++) begin
      rdy_mode = $urandom_range(0, 1);
      dv_mode  = $urandom_range(0, 1);
      addr = {$urandom, 20'($urandom), 6'($urandom), 6'd0};
      if ($urandom_range(0, 6) == 0) addr[5:0] = 6'($urandom_range(1, 63));
      len = 8'($urandom_range(0, 15));
      do_req(addr, len, 2'($urandom));
    end

`ifdef PCIM_WR_TIMEOUT_EN
    begin
      bit ok;
      int n;
      aw_t a;
      w_t w;
      logic [511:0] d;
      rdy_mode = 0; dv_mode = 0;
      b_en = 1'b0;
      a.addr = 64'h9000; a.len = 8'd1;
      aw_q.push_back(a);
      for (int i = 0; i < 2; i++) begin
        d = rand512();
        src_q.push_back(d);
        w.d = d; w.last = (i == 1);
        w_q.push_back(w);
      end
      done_q.push_back(2'b11);
      bq.push_back(2'b00);
      issue(64'h9000, 8'd1, ok);
      n = 0;
      while (!pcim_if.cl_sh_pcim_bready && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (!done_valid && n < 200) begin @(negedge clk); n++; end
      check("timeout_cycles_in_resp", 64'(n), 64'd16);
      @(negedge clk);
      b_en = 1'b1;
      repeat (30) @(negedge clk);
      check("late_b_consumed", 64'(bq.size()), 64'd0);
      check("late_b_no_done", 64'(done_q.size()), 64'd0);
      do_req(64'hA000, 8'd2, 2'b00);
    end
`endif

    repeat (5) @(negedge clk);
    check("queues_drained", 64'(aw_q.size() + w_q.size() + done_q.size() + src_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
